mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- N-channel round-robin arbiter that multiplexes cache-side memory requests onto one downstream memory port.
- Generalises the current fixed two-port (inst/data) top-level memory interface to NUM_CH channels, parametrised in address and data width.
- Sits between the pipeline's cache ports and a single shared cache or physical-memory port.
- Serves one transaction at a time and holds the grant until the downstream response.

Parameters:
- NUM_CH, 2, number of requester channels (>=1).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8). MBE_W = DATA_W/8 is a derived localparam, not overridable.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- req_read  in  NUM_CH  per-channel read request.
- req_write  in  NUM_CH  per-channel write request.
- req_mbe  in  NUM_CH*MBE_W  per-channel byte enables. Channel i uses slice [i*MBE_W +: MBE_W].
- req_addr  in  NUM_CH*ADDR_W  per-channel address, packed the same way.
- req_wdata  in  NUM_CH*DATA_W  per-channel write data, packed the same way.
- req_resp  out  NUM_CH  per-channel response pulse.
- req_rdata  out  DATA_W  read data, broadcast to all channels.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_mbe  out  MBE_W  downstream byte enables.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_resp  in  1  downstream response.
- mem_rdata  in  DATA_W  downstream read data.

Behaviour:
- Reset values:
  - mem_read=0, mem_write=0, mem_mbe=0, mem_addr=0, mem_wdata=0.
  - req_resp=0.
  - state=IDLE.
  - last_grant=NUM_CH-1, so channel 0 has first priority after reset.
- Channel i is "requesting" when req_read[i] or req_write[i] is high.
- Requesters hold their request and operands stable until they see req_resp[i].
- State IDLE:
  - If any channel is requesting, grant the first requesting channel found searching upward (modulo NUM_CH) from last_grant+1.
  - On grant, latch into output registers: grant index, op, mbe, addr, wdata.
  - Update last_grant to the granted channel and go to BUSY.
  - If no channel is requesting, stay in IDLE with mem_read and mem_write low.
- State BUSY:
  - mem_* are driven from the latched registers and stay constant until mem_resp.
  - In the cycle mem_resp=1:
    - req_resp[grant]=1, combinational from mem_resp while in BUSY.
    - All other bits of req_resp are 0.
    - Next state is IDLE, and mem_read/mem_write are registered low.
- Latency:
  - A request first visible in cycle N with the arbiter IDLE produces mem_read/mem_write high in cycle N+1.
  - The requester's resp arrives in the same cycle as mem_resp.
  - The minimum gap between back-to-back transactions is one IDLE cycle.
- Op encoding: if req_read and req_write are both high on one channel, it is treated as a write (mem_write=1, mem_read=0).
- req_rdata equals mem_rdata at all times. Its value is only meaningful when req_resp is high.
- For a read op, mem_wdata is the latched value but is don't-care downstream. mem_mbe is passed through for both reads and writes.
- mem_resp:
  - Ignored in IDLE; no req_resp is generated.
  - Assumed a single-cycle pulse.
- Requests that drop in BUSY: a request on a non-granted channel that drops while the arbiter is BUSY is simply never granted.
- Fairness: with all channels continuously requesting, grants rotate 0,1,...,NUM_CH-1,0,...
- NUM_CH=1: always grants channel 0. The logic must still elaborate with a zero-width-safe index (minimum 1 bit).
- Reset mid-transaction:
  - Immediately return to IDLE with the reset values above.
  - The in-flight downstream transaction is abandoned.
  - A mem_resp arriving afterwards is ignored.

Optional Feature:
- Macro ARB_PERF_CTR_EN.
- When defined:
  - Adds output port grant_cnt, width NUM_CH*32.
  - Each channel has a 32-bit saturating counter, incremented once per grant of that channel.
  - Counters are cleared by rst and hold at 32'hFFFF_FFFF.
- When undefined: the port and counters are absent, and all other behaviour is identical.

Test Plan:
1. rst held 2 cycles, then released with no requests -> mem_read=0, mem_write=0, req_resp=0 for 10 cycles.
2. NUM_CH=2, ch0 read addr 32'h0000_1000 at cycle 5; memory model responds 3 cycles later with rdata 32'hDEAD_BEEF:
   - mem_read=1 and mem_addr=32'h1000 from cycle 6.
   - req_resp=2'b01 and req_rdata=32'hDEADBEEF in the mem_resp cycle.
3. NUM_CH=4, all channels requesting continuously -> grant order 0,1,2,3,0,1; each channel gets exactly one resp per 4 transactions.
4. Ch1 write, addr 32'h2004, wdata 32'h1234_5678, mbe 4'b0011, while ch0 idle:
   - mem_write=1 with exactly those values, held stable until mem_resp.
   - Then req_resp=2'b10.
5. rst asserted while BUSY waiting on mem_resp, then mem_resp pulsed 1 cycle after reset release:
   - mem_* go to 0 and req_resp stays 0.
   - The next request is granted to channel 0 first.
6. With ARB_PERF_CTR_EN defined: 5 grants to ch1 and 2 grants to ch0 -> grant_cnt slice 1 = 5 and slice 0 = 2; rst clears both to 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// N-channel round-robin arbiter that funnels cache-side memory requests onto
// a single downstream memory port. One transaction is in flight at a time; the
// grant is held from the cycle the request is latched until the downstream
// response arrives.
//
// Optional feature: define ARB_PERF_CTR_EN to add per-channel 32-bit
// saturating grant counters on output port grant_cnt.

module mem_port_arbiter #(
    parameter  int NUM_CH = 2,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int MBE_W  = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_read,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*MBE_W-1:0]    req_mbe,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          req_resp,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [MBE_W-1:0]           mem_mbe,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_resp,
    input  logic [DATA_W-1:0]          mem_rdata
`ifdef ARB_PERF_CTR_EN
    ,
    output logic [NUM_CH*32-1:0]       grant_cnt
`endif
);

    // Channel index width; a single channel still gets a 1-bit index.
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Arbiter states.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    // After reset the last grant points at the top channel so channel 0 wins first.
    localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // State and latched transaction registers
    // ------------------------------------------------------------------
    logic [0:0]         state_q,      state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   grant_q,      grant_d;
    logic               mem_read_q,   mem_read_d;
    logic               mem_write_q,  mem_write_d;
    logic [MBE_W-1:0]   mem_mbe_q,    mem_mbe_d;
    logic [ADDR_W-1:0]  mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q,  mem_wdata_d;

    // ------------------------------------------------------------------
    // Per-channel views of the packed request buses
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]  req_any_s;
    logic [MBE_W-1:0]   mbe_arr_s   [NUM_CH];
    logic [ADDR_W-1:0]  addr_arr_s  [NUM_CH];
    logic [DATA_W-1:0]  wdata_arr_s [NUM_CH];

    assign req_any_s = req_read | req_write;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign mbe_arr_s[g]   = req_mbe[g*MBE_W +: MBE_W];
        assign addr_arr_s[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr_s[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first requester searching upward from last_grant+1
    // ------------------------------------------------------------------
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [IDX_W-1:0]   cand_s;
    logic               pick_wr_s;
    logic               pick_rd_s;

    // Scan channels in rotating priority order and keep the first hit.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = last_grant_q;
        cand_s       = last_grant_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_s = IDX_W'((int'(last_grant_q) + k) % NUM_CH);
            if (!pick_found_s && req_any_s[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // A channel raising both read and write is served as a write.
    assign pick_wr_s = req_write[pick_idx_s];
    assign pick_rd_s = req_read[pick_idx_s] & ~pick_wr_s;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Decide grant, latch operands on grant, and drop the op on response.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_mbe_d    = mem_mbe_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    state_d      = S_BUSY;
                    last_grant_d = pick_idx_s;
                    grant_d      = pick_idx_s;
                    mem_read_d   = pick_rd_s;
                    mem_write_d  = pick_wr_s;
                    mem_mbe_d    = mbe_arr_s[pick_idx_s];
                    mem_addr_d   = addr_arr_s[pick_idx_s];
                    mem_wdata_d  = wdata_arr_s[pick_idx_s];
                end else begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            S_BUSY: begin
                if (mem_resp) begin
                    state_d     = S_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: begin
                state_d     = S_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_GRANT_RST;
            grant_q      <= {IDX_W{1'b0}};
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_mbe_q    <= {MBE_W{1'b0}};
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_mbe_q    <= mem_mbe_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Responses back to the requesters
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] req_resp_s;

    // Route the downstream response pulse to the granted channel only while busy.
    always_comb begin
        req_resp_s = {NUM_CH{1'b0}};
        if ((state_q == S_BUSY) && mem_resp) begin
            req_resp_s[grant_q] = 1'b1;
        end else begin
            req_resp_s = {NUM_CH{1'b0}};
        end
    end

    assign req_resp  = req_resp_s;
    assign req_rdata = mem_rdata;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_mbe   = mem_mbe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef ARB_PERF_CTR_EN
    // ------------------------------------------------------------------
    // Per-channel saturating grant counters
    // ------------------------------------------------------------------
    logic [31:0] grant_cnt_q [NUM_CH];

    // Count one per grant; hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                grant_cnt_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((state_q == S_IDLE) && pick_found_s &&
                    (pick_idx_s == IDX_W'(i)) &&
                    (grant_cnt_q[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_pack
        assign grant_cnt[g*32 +: 32] = grant_cnt_q[g];
    end
`endif

endmodule
